// File: rtl/wght_fetch_ctrl.sv
// Weight RAM read initiator: streams LEN words from BASE_ADDR over valid/ready through a credit FIFO.
// Optional stall counter port enabled by defining WGHT_FETCH_PERF_EN.
module wght_fetch_ctrl #(
  parameter int BIT_WIDTH      = 31,
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int RD_LAT         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   len,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  output logic                      ren,
  input  logic [BIT_WIDTH:0]        rdat,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BIT_WIDTH:0]        m_data,
  output logic                      m_last
`ifdef WGHT_FETCH_PERF_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int AW         = RAM_ADDR_WIDTH;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CREDITS   = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_pend;
  logic [AW:0]      r_remain;
  logic             r_ren_last;
  logic [RD_LAT-1:0] r_tag_v;
  logic [RD_LAT-1:0] r_tag_l;
  logic [BIT_WIDTH:0] r_fdat [FIFO_DEPTH];
  logic             r_flast [FIFO_DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_out;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [CW-1:0]    w_out_next;

  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign m_valid = (r_cnt != '0);
  assign m_data  = r_fdat[r_rd];
  assign m_last  = m_valid && r_flast[r_rd];

  // r_out counts words issued but not yet popped, so it covers both in-flight reads and FIFO entries.
  always_comb begin
    w_push     = r_tag_v[RD_LAT-1];
    w_pop      = m_valid && m_ready;
    w_out_next = r_out + CW'(ren) - CW'(w_pop);
    w_issue    = (r_state == FETCH) && (r_remain != '0) && (w_out_next < CREDITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ren        <= 1'b0;
      raddr      <= '0;
      r_pend     <= '0;
      r_remain   <= '0;
      r_ren_last <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              r_state    <= FETCH;
              busy       <= 1'b1;
              ren        <= 1'b1;
              raddr      <= base_addr;
              r_pend     <= f_next_addr(base_addr);
              r_remain   <= len - 1'b1;
              r_ren_last <= (len == LEN_ONE);
            end
          end
        end
        FETCH: begin
          ren <= w_issue;
          if (w_issue) begin
            raddr      <= r_pend;
            r_pend     <= f_next_addr(r_pend);
            r_remain   <= r_remain - 1'b1;
            r_ren_last <= (r_remain == LEN_ONE);
          end
          if (r_remain == '0) r_state <= DRAIN;
        end
        DRAIN: begin
          ren <= 1'b0;
          if (w_pop && m_last) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      r_tag_l <= '0;
      r_fdat  <= '{default: '0};
      r_flast <= '{default: 1'b0};
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_tag_v[0] <= ren;
      r_tag_l[0] <= ren && r_ren_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_l[i] <= r_tag_l[i-1];
      end
      if (w_push) begin
        r_fdat[r_wr]  <= rdat;
        r_flast[r_wr] <= r_tag_l[RD_LAT-1];
        r_wr          <= (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_out <= w_out_next;
    end
  end

`ifdef WGHT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
